// File: rtl/matmul_pkg.sv
// matmul_pkg: loader state encoding and line-geometry helpers shared by the input loader.
package matmul_pkg;
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        WAIT_WR  = 3'd2,
        WAIT_FSM = 3'd3,
        START    = 3'd4,
        DONE     = 3'd5
    } loader_state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int num_lines(input int rows, input int cols, input int ws, input int mpw);
        return ceil_div(2 * rows * cols, mpw / ws);
    endfunction

    localparam int WPL       = 64 / 16;
    localparam int NUM_ELEM  = 2 * 4 * 4;
    localparam int NUM_LINES = ceil_div(NUM_ELEM, WPL);
endpackage

// File: rtl/matmul_input_loader_line_packer.sv
// line_packer: gathers host elements into a RAM line, lane 0 in the LSBs.
// packed_line already includes the current beat so the caller can register it on the trigger beat.
module line_packer #(
    parameter int WORD_SIZE      = 16,
    parameter int MEM_PORT_WIDTH = 64,
    parameter int NUM_ELEM       = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      beat,
    input  logic [WORD_SIZE-1:0]      in_data,
    output logic [MEM_PORT_WIDTH-1:0] packed_line,
    output logic                      full,
    output logic                      last
);
    localparam int WPL = MEM_PORT_WIDTH / WORD_SIZE;
    localparam int LW  = WPL > 1 ? $clog2(WPL) : 1;
    localparam int EW  = $clog2(NUM_ELEM + 1);

    logic [MEM_PORT_WIDTH-1:0] line_q;
    logic [LW-1:0]             lane;
    logic [EW-1:0]             elem_cnt;

    always_comb begin
        packed_line = line_q;
        packed_line[lane*WORD_SIZE +: WORD_SIZE] = in_data;
    end

    assign full = lane == LW'(WPL - 1);
    assign last = elem_cnt == EW'(NUM_ELEM - 1);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            line_q   <= '0;
            lane     <= '0;
            elem_cnt <= '0;
        end else if (clr) begin
            line_q   <= '0;
            lane     <= '0;
            elem_cnt <= '0;
        end else if (beat) begin
            elem_cnt <= elem_cnt + 1'b1;
            line_q   <= full || last ? '0 : packed_line;
            lane     <= full || last ? '0 : lane + 1'b1;
        end
endmodule

// File: rtl/matmul_input_loader.sv
// matmul_input_loader: streams the top and left matrices into the input RAM, then starts the matmul FSM.
module matmul_input_loader
    import matmul_pkg::*;
#(
    parameter int          ROWS           = 4,
    parameter int          COLS           = 4,
    parameter int          WORD_SIZE      = 16,
    parameter int          MEM_PORT_WIDTH = 64,
    parameter logic [31:0] BASE_ADDR      = 32'd0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WORD_SIZE-1:0]      in_data,
    output logic [31:0]               mem_addr,
    output logic                      mem_wr_en,
    output logic [MEM_PORT_WIDTH-1:0] mem_wr_data,
    input  logic                      mem_wr_ready,
    input  logic                      fsm_rdy,
    output logic                      inputs_rdy,
    output logic                      start_fsm,
    output logic                      busy
);
    localparam int NE  = 2 * ROWS * COLS;
    localparam int NL  = num_lines(ROWS, COLS, WORD_SIZE, MEM_PORT_WIDTH);
    localparam int LCW = $clog2(NL + 1);

    loader_state_t             state, state_nxt;
    logic                      beat, wr_acc, full, last, clr;
    logic [MEM_PORT_WIDTH-1:0] packed_line;
    logic [LCW-1:0]            line_cnt;

    assign in_ready = state == LOAD && !(mem_wr_en && !mem_wr_ready);
    assign beat     = in_valid && in_ready;
    assign wr_acc   = mem_wr_en && mem_wr_ready;
    assign busy     = state == LOAD || state == WAIT_WR;
    assign clr      = (state == IDLE || state == DONE) && load_start;

    line_packer #(
        .WORD_SIZE     (WORD_SIZE),
        .MEM_PORT_WIDTH(MEM_PORT_WIDTH),
        .NUM_ELEM      (NE)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .beat       (beat),
        .in_data    (in_data),
        .packed_line(packed_line),
        .full       (full),
        .last       (last)
    );

    always_comb
        case (state)
            IDLE, DONE: state_nxt = load_start ? LOAD : state;
            LOAD:       state_nxt = beat && last ? WAIT_WR : LOAD;
            WAIT_WR:    state_nxt = wr_acc ? WAIT_FSM : WAIT_WR;
            WAIT_FSM:   state_nxt = fsm_rdy ? START : WAIT_FSM;
            START:      state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state       <= IDLE;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= '0;
            mem_addr    <= '0;
            line_cnt    <= '0;
            inputs_rdy  <= 1'b0;
            start_fsm   <= 1'b0;
        end else begin
            state     <= state_nxt;
            start_fsm <= state == WAIT_FSM && fsm_rdy;
            if (clr) begin
                line_cnt   <= '0;
                inputs_rdy <= 1'b0;
            end else if (state == WAIT_WR && wr_acc)
                inputs_rdy <= 1'b1;
            if (wr_acc) begin
                mem_wr_en <= 1'b0;
                line_cnt  <= line_cnt + 1'b1;
            end
            // a write retiring this cycle has already claimed line_cnt, so the new line goes one past it
            if (beat && (full || last)) begin
                mem_wr_en   <= 1'b1;
                mem_wr_data <= packed_line;
                mem_addr    <= BASE_ADDR + 32'(line_cnt) + {31'd0, wr_acc};
            end
        end
endmodule

// File: tb/tb_matmul_input_loader.sv
// tb_matmul_input_loader: directed checks of a 2x2 and a 3x3 loader (8-bit elements, 32-bit lines).
module tb_matmul_input_loader;
    logic        clk = 0, rst = 1, mem_wr_ready = 1, fsm_rdy = 1;
    logic        ls2 = 0, iv2 = 0, ir2, we2, irdy2, st2, busy2;
    logic [7:0]  id2 = 0;
    logic [31:0] addr2, wd2;
    logic        ls3 = 0, iv3 = 0, ir3, we3, irdy3, st3, busy3;
    logic [7:0]  id3 = 0;
    logic [31:0] addr3, wd3;
    logic [31:0] ram2 [16];
    logic [31:0] ram3 [16];
    int          wc2 = 0, wc3 = 0, starts2 = 0, total = 0, bad = 0, s0 = 0;

    always #5 clk = ~clk;

    matmul_input_loader #(.ROWS(2), .COLS(2), .WORD_SIZE(8), .MEM_PORT_WIDTH(32), .BASE_ADDR(32'h10)) d2 (
        .clk(clk), .rst(rst), .load_start(ls2), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
        .mem_addr(addr2), .mem_wr_en(we2), .mem_wr_data(wd2), .mem_wr_ready(mem_wr_ready),
        .fsm_rdy(fsm_rdy), .inputs_rdy(irdy2), .start_fsm(st2), .busy(busy2));

    matmul_input_loader #(.ROWS(3), .COLS(3), .WORD_SIZE(8), .MEM_PORT_WIDTH(32), .BASE_ADDR(32'h10)) d3 (
        .clk(clk), .rst(rst), .load_start(ls3), .in_valid(iv3), .in_ready(ir3), .in_data(id3),
        .mem_addr(addr3), .mem_wr_en(we3), .mem_wr_data(wd3), .mem_wr_ready(mem_wr_ready),
        .fsm_rdy(fsm_rdy), .inputs_rdy(irdy3), .start_fsm(st3), .busy(busy3));

    always @(posedge clk) begin
        if (we2 && mem_wr_ready) begin
            ram2[addr2[3:0]] <= wd2;
            wc2 <= wc2 + 1;
        end
        if (we3 && mem_wr_ready) begin
            ram3[addr3[3:0]] <= wd3;
            wc3 <= wc3 + 1;
        end
        if (st2) starts2 <= starts2 + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input bit t3);
        if (t3) ls3 = 1; else ls2 = 1;
        tick(1);
        ls2 = 0;
        ls3 = 0;
    endtask

    task automatic push(input bit t3, input logic [7:0] v);
        int n = 0;
        if (t3) begin iv3 = 1; id3 = v; end
        else begin iv2 = 1; id2 = v; end
        #1;
        while (!(t3 ? ir3 : ir2) && n < 50) begin
            tick(1);
            n++;
        end
        chk("beat_timeout", 64'(n < 50), 64'd1);
        tick(1);
        iv2 = 0;
        iv3 = 0;
    endtask

    initial begin
        #1;
        chk("rst_busy", 64'(busy2), 0);
        chk("rst_wr_en", 64'(we2), 0);
        chk("rst_irdy", 64'(irdy2), 0);
        tick(2);
        rst = 0;
        tick(1);

        // 2x2 basic stream
        load(0);
        chk("t1_busy", 64'(busy2), 1);
        chk("t1_in_ready", 64'(ir2), 1);
        for (int v = 1; v <= 4; v++) push(0, 8'(v));
        chk("t1_w0_en", 64'(we2), 1);
        chk("t1_w0_addr", 64'(addr2), 64'h10);
        chk("t1_w0_data", 64'(wd2), 64'h04030201);
        for (int v = 5; v <= 8; v++) push(0, 8'(v));
        chk("t1_w1_en", 64'(we2), 1);
        chk("t1_w1_addr", 64'(addr2), 64'h11);
        chk("t1_w1_data", 64'(wd2), 64'h08070605);
        chk("t1_wait_wr_ready", 64'(ir2), 0);
        chk("t1_irdy_early", 64'(irdy2), 0);
        tick(1);
        chk("t1_irdy", 64'(irdy2), 1);
        chk("t1_start_early", 64'(st2), 0);
        tick(1);
        chk("t1_start", 64'(st2), 1);
        tick(1);
        chk("t1_start_off", 64'(st2), 0);
        chk("t1_done_busy", 64'(busy2), 0);
        chk("t1_done_irdy", 64'(irdy2), 1);
        chk("t1_ram0", 64'(ram2[0]), 64'h04030201);
        chk("t1_ram1", 64'(ram2[1]), 64'h08070605);
        chk("t1_wcount", 64'(wc2), 2);
        chk("t1_starts", 64'(starts2), 1);

        // in_valid in DONE is ignored
        iv2 = 1;
        id2 = 8'h99;
        #1;
        chk("done_in_ready", 64'(ir2), 0);
        tick(3);
        iv2 = 0;
        chk("done_wcount", 64'(wc2), 2);
        chk("done_irdy", 64'(irdy2), 1);

        // write stall on the first line
        mem_wr_ready = 0;
        load(0);
        for (int v = 1; v <= 4; v++) push(0, 8'(v));
        iv2 = 1;
        id2 = 8'h05;
        #1;
        repeat (5) begin
            chk("stall_in_ready", 64'(ir2), 0);
            chk("stall_addr", 64'(addr2), 64'h10);
            chk("stall_data", 64'(wd2), 64'h04030201);
            tick(1);
        end
        mem_wr_ready = 1;
        iv2 = 0;
        for (int v = 5; v <= 8; v++) push(0, 8'(v));
        tick(3);
        chk("stall_ram0", 64'(ram2[0]), 64'h04030201);
        chk("stall_ram1", 64'(ram2[1]), 64'h08070605);
        chk("stall_wcount", 64'(wc2), 4);

        // fsm_rdy held low, plus load_start during LOAD
        fsm_rdy = 0;
        load(0);
        push(0, 8'h01);
        push(0, 8'h02);
        ls2 = 1;
        tick(1);
        ls2 = 0;
        chk("ls_in_load_busy", 64'(busy2), 1);
        for (int v = 3; v <= 8; v++) push(0, 8'(v));
        tick(1);
        s0 = starts2;
        repeat (10) begin
            chk("fsm_wait_irdy", 64'(irdy2), 1);
            chk("fsm_wait_start", 64'(st2), 0);
            tick(1);
        end
        fsm_rdy = 1;
        tick(3);
        chk("fsm_one_start", 64'(starts2 - s0), 1);
        chk("fsm_ram0", 64'(ram2[0]), 64'h04030201);
        chk("fsm_ram1", 64'(ram2[1]), 64'h08070605);
        chk("fsm_wcount", 64'(wc2), 6);

        // reload from DONE overwrites the same lines
        chk("reload_irdy_before", 64'(irdy2), 1);
        load(0);
        chk("reload_irdy_cleared", 64'(irdy2), 0);
        for (int v = 8'h31; v <= 8'h38; v++) push(0, 8'(v));
        tick(3);
        chk("reload_ram0", 64'(ram2[0]), 64'h34333231);
        chk("reload_ram1", 64'(ram2[1]), 64'h38373635);

        // asynchronous reset mid-load
        load(0);
        for (int v = 8'h41; v <= 8'h43; v++) push(0, 8'(v));
        #2 rst = 1;
        #1;
        chk("arst_busy", 64'(busy2), 0);
        chk("arst_in_ready", 64'(ir2), 0);
        chk("arst_wr_en", 64'(we2), 0);
        chk("arst_wr_data", 64'(wd2), 0);
        chk("arst_addr", 64'(addr2), 0);
        chk("arst_irdy", 64'(irdy2), 0);
        tick(1);
        rst = 0;
        tick(1);
        load(0);
        for (int v = 8'h21; v <= 8'h28; v++) push(0, 8'(v));
        tick(3);
        chk("arst_ram0", 64'(ram2[0]), 64'h24232221);
        chk("arst_ram1", 64'(ram2[1]), 64'h28272625);

        // 3x3: 18 elements, padded final line
        load(1);
        for (int v = 1; v <= 18; v++) push(1, 8'(v));
        chk("t2_last_en", 64'(we3), 1);
        chk("t2_last_addr", 64'(addr3), 64'h14);
        chk("t2_last_data", 64'(wd3), 64'h00001211);
        tick(1);
        chk("t2_irdy", 64'(irdy3), 1);
        tick(3);
        chk("t2_ram0", 64'(ram3[0]), 64'h04030201);
        chk("t2_ram2", 64'(ram3[2]), 64'h0C0B0A09);
        chk("t2_ram4", 64'(ram3[4]), 64'h00001211);
        chk("t2_wcount", 64'(wc3), 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
